// File: rtl/weighted_arbiter_pkg.sv
// Shared constants and helpers for the weighted two-class arbiter.
// Widths are taken from each module's own parameters; only the ceiling lives here.
package weighted_arbiter_pkg;

  localparam int MAX_REQUESTERS = 32;

  // Binary index of the lowest set bit; 0 when the vector is empty.
  function automatic int oh_to_idx(input logic [MAX_REQUESTERS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = MAX_REQUESTERS - 1; i >= 0; i--) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/weighted_arbiter_rr_pick.sv
// Combinational round-robin pick: the first requester at or above the one-hot
// pointer wins, wrapping around to the lowest requester when none is above it.
module rr_pick #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [NUM_REQUESTERS-1:0] priority_oh,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  logic [NUM_REQUESTERS-1:0] masked;
  logic [NUM_REQUESTERS-1:0] masked_low;
  logic [NUM_REQUESTERS-1:0] plain_low;

  // Requests at or above the pointer; x & -x isolates the lowest set bit.
  always_comb begin
    masked     = request & ~(priority_oh - NUM_REQUESTERS'(1));
    masked_low = masked & (~masked + NUM_REQUESTERS'(1));
    plain_low  = request & (~request + NUM_REQUESTERS'(1));
    grant_oh   = (|masked) ? masked_low : plain_low;
  end

endmodule

// File: rtl/weighted_arbiter.sv
// Two-class weighted round-robin arbiter with burst credits and grant locking.
// The grant is combinational; pointers, burst holder and lock state are registered.
module weighted_arbiter
  import weighted_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int WEIGHT_WIDTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQUESTERS-1:0]              request,
  input  logic [NUM_REQUESTERS-1:0]              high_priority,
  input  logic [NUM_REQUESTERS*WEIGHT_WIDTH-1:0] weight,
  input  logic                                   grant_accept,
  input  logic                                   lock,
  output logic [NUM_REQUESTERS-1:0]              grant_oh,
  output logic [$clog2(NUM_REQUESTERS)-1:0]      grant_idx,
  output logic                                   grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] hi_ptr;
  logic [NUM_REQUESTERS-1:0] lo_ptr;
  logic [NUM_REQUESTERS-1:0] holder_oh;
  logic [NUM_REQUESTERS-1:0] lock_oh;
  logic                      holder_valid;
  logic                      locked;
  logic [WEIGHT_WIDTH-1:0]   credits;

  logic [NUM_REQUESTERS-1:0] hi_req;
  logic [NUM_REQUESTERS-1:0] lo_req;
  logic [NUM_REQUESTERS-1:0] hi_pick;
  logic [NUM_REQUESTERS-1:0] lo_pick;
  logic                      holder_req;
  logic                      holder_hi;
  logic                      continue_burst;
  logic                      grant_hi;
  logic                      grant_is_cont;
  logic                      accept_ev;
  logic [WEIGHT_WIDTH-1:0]   sel_weight;
  logic [WEIGHT_WIDTH-1:0]   load_credits;
  logic [WEIGHT_WIDTH-1:0]   dec_credits;
  logic [NUM_REQUESTERS-1:0] grant_rot;

  assign hi_req = request & high_priority;
  assign lo_req = request & ~high_priority;

  rr_pick #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_hi_pick (
    .request     (hi_req),
    .priority_oh (hi_ptr),
    .grant_oh    (hi_pick)
  );

  rr_pick #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_lo_pick (
    .request     (lo_req),
    .priority_oh (lo_ptr),
    .grant_oh    (lo_pick)
  );

  // A low-class burst yields to any high-class request; a high-class one never does.
  always_comb begin
    holder_req     = |(holder_oh & request);
    holder_hi      = |(holder_oh & high_priority);
    continue_burst = holder_valid && holder_req && (holder_hi || !(|hi_req));
    if (locked)              grant_oh = lock_oh;
    else if (continue_burst) grant_oh = holder_oh;
    else if (|hi_req)        grant_oh = hi_pick;
    else                     grant_oh = lo_pick;
  end

  assign grant_valid = |grant_oh;
  assign grant_idx   = IDX_W'(oh_to_idx(MAX_REQUESTERS'(grant_oh)));
  assign grant_hi    = |(grant_oh & high_priority);
  assign accept_ev   = grant_accept && grant_valid;
  assign grant_rot   = {grant_oh[NUM_REQUESTERS-2:0], grant_oh[NUM_REQUESTERS-1]};

  // Under lock the owner is also the holder, so its beats count against its burst.
  assign grant_is_cont = locked ? (holder_valid && (holder_oh == grant_oh)) : continue_burst;

  always_comb begin
    sel_weight = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_oh[i]) sel_weight = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
    load_credits = (sel_weight == '0) ? '0 : sel_weight - WEIGHT_WIDTH'(1);
    dec_credits  = (credits == '0) ? '0 : credits - WEIGHT_WIDTH'(1);
  end

  // A new grant replaces the holder outright, which is how a preempted burst is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_ptr       <= NUM_REQUESTERS'(1);
      lo_ptr       <= NUM_REQUESTERS'(1);
      holder_oh    <= '0;
      holder_valid <= 1'b0;
      credits      <= '0;
      locked       <= 1'b0;
      lock_oh      <= '0;
    end else if (accept_ev) begin
      locked <= lock;
      if (lock) lock_oh <= grant_oh;
      if (grant_is_cont) begin
        credits <= dec_credits;
        if (dec_credits == '0 && !lock) holder_valid <= 1'b0;
      end else begin
        if (grant_hi) hi_ptr <= grant_rot;
        else          lo_ptr <= grant_rot;
        holder_oh    <= grant_oh;
        credits      <= load_credits;
        holder_valid <= (load_credits != '0) || lock;
      end
    end else if (holder_valid && !holder_req && !locked) begin
      holder_valid <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (reset) $onehot0(grant_oh));

endmodule

// File: tb/tb_weighted_arbiter.sv
// Directed-vector bench for weighted_arbiter (4 requesters, 4-bit weights).
// Each beat drives inputs after a falling edge and checks the combinational grant.
module tb_weighted_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  request;
  logic [3:0]  high_priority;
  logic [15:0] weight;
  logic        grant_accept;
  logic        lock;
  logic [3:0]  grant_oh;
  logic [1:0]  grant_idx;
  logic        grant_valid;

  int assert_count;
  int fail_count;

  weighted_arbiter #(.NUM_REQUESTERS(4), .WEIGHT_WIDTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .request       (request),
    .high_priority (high_priority),
    .weight        (weight),
    .grant_accept  (grant_accept),
    .lock          (lock),
    .grant_oh      (grant_oh),
    .grant_idx     (grant_idx),
    .grant_valid   (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // idx < 0 means no grant is expected.
  task automatic expectGrant(input string tag, input int idx);
    logic [3:0] exp_oh;
    exp_oh = (idx < 0) ? 4'b0000 : 4'(1 << idx);
    checkOutput({tag, "_oh"}, 32'(grant_oh), 32'(exp_oh));
    checkOutput({tag, "_idx"}, 32'(grant_idx), (idx < 0) ? 32'd0 : 32'(idx));
    checkOutput({tag, "_valid"}, 32'(grant_valid), (idx < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic acc, input logic lk);
    @(negedge clk);
    request      = req;
    grant_accept = acc;
    lock         = lk;
    #1;
  endtask

  task automatic doReset(input logic [15:0] w, input logic [3:0] hp);
    @(negedge clk);
    reset         = 1'b1;
    request       = '0;
    grant_accept  = 1'b0;
    lock          = 1'b0;
    weight        = w;
    high_priority = hp;
    @(negedge clk);
    #1;
    expectGrant("reset", -1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runSequence(input string tag, input logic [3:0] req, input int exp_seq[$]);
    foreach (exp_seq[k]) begin
      applyStimulus(req, 1'b1, 1'b0);
      expectGrant($sformatf("%s_%0d", tag, k), exp_seq[k]);
    end
  endtask

  initial begin
    assert_count  = 0;
    fail_count    = 0;
    reset         = 1'b1;
    request       = '0;
    grant_accept  = 1'b0;
    lock          = 1'b0;
    weight        = 16'h1111;
    high_priority = 4'b0000;

    // Plain round robin, then weight 0 behaving as weight 1.
    doReset(16'h1111, 4'b0000);
    runSequence("rr", 4'b1111, '{0, 1, 2, 3, 0});
    doReset(16'h0000, 4'b0000);
    runSequence("w0", 4'b1111, '{0, 1, 2, 3});

    // Requester 1 with weight 3.
    doReset(16'h0031, 4'b0000);
    runSequence("burst", 4'b0011, '{0, 1, 1, 1, 0, 1, 1, 1});

    // High-class preemption of a low-class burst, then a fresh burst on pointer turn.
    doReset(16'h1411, 4'b1000);
    applyStimulus(4'b0100, 1'b1, 1'b0); expectGrant("pre_a", 2);
    applyStimulus(4'b0100, 1'b1, 1'b0); expectGrant("pre_b", 2);
    applyStimulus(4'b1100, 1'b1, 1'b0); expectGrant("pre_hi", 3);
    runSequence("pre_after", 4'b0101, '{0, 2, 2, 2, 2, 0});

    // Holder releases its burst when its request drops without a grant.
    doReset(16'h1411, 4'b0000);
    applyStimulus(4'b0100, 1'b1, 1'b0); expectGrant("drop_a", 2);
    applyStimulus(4'b0001, 1'b0, 1'b0); expectGrant("drop_b", 0);
    applyStimulus(4'b0101, 1'b0, 1'b0); expectGrant("drop_c", 0);

    // Lock holds the grant on requester 1 after its request drops.
    doReset(16'h1111, 4'b0000);
    applyStimulus(4'b0010, 1'b1, 1'b1); expectGrant("lock_set", 1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0001, 1'b1, 1'b1);
      expectGrant($sformatf("lock_hold_%0d", k), 1);
    end
    applyStimulus(4'b0001, 1'b1, 1'b0); expectGrant("lock_rel", 1);
    applyStimulus(4'b0001, 1'b0, 1'b0); expectGrant("lock_after", 0);

    // Reset during a lock abandons it.
    doReset(16'h1111, 4'b0000);
    applyStimulus(4'b0100, 1'b1, 1'b1); expectGrant("rlock_set", 2);
    applyStimulus(4'b0000, 1'b0, 1'b0); expectGrant("rlock_held", 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expectGrant("rlock_reset", -1);
    @(negedge clk);
    reset   = 1'b0;
    request = 4'b1000;
    #1;
    expectGrant("rlock_post", 3);
    applyStimulus(4'b1001, 1'b0, 1'b0); expectGrant("rlock_ptr", 0);

    // No accept: grant and state stay frozen.
    doReset(16'h1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0110, 1'b0, 1'b0);
      expectGrant($sformatf("idle_%0d", k), 1);
    end
    applyStimulus(4'b0110, 1'b1, 1'b0); expectGrant("idle_acc", 1);
    applyStimulus(4'b0110, 1'b0, 1'b0); expectGrant("idle_next", 2);

    // Mixed classes: high class rotates among itself, low waits.
    doReset(16'h1111, 4'b0101);
    runSequence("cls_hi", 4'b1111, '{0, 2, 0, 2});
    runSequence("cls_lo", 4'b1010, '{1, 3, 1});

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/weighted_arbiter.md
WEIGHTED_ARBITER -- requirements
Module: weighted_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, meaning the number of requesters (2..32).
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4, meaning the width of the per-requester burst weight.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port request, input, NUM_REQUESTERS, one bit per requester wanting access.
REQ-006 SHALL have port high_priority, input, NUM_REQUESTERS, class of each requester (1 = high); quasi-static.
REQ-007 SHALL have port weight, input, NUM_REQUESTERS*WEIGHT_WIDTH, consecutive grants per turn, requester i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; quasi-static.
REQ-008 SHALL have port grant_accept, input, 1, the current grant is consumed this cycle.
REQ-009 SHALL have port lock, input, 1, sampled with grant_accept, holds the grant for the next beat.
REQ-010 SHALL have port grant_oh, output, NUM_REQUESTERS, one-hot (or zero) grant, combinational from same-cycle inputs.
REQ-011 SHALL have port grant_idx, output, $clog2(NUM_REQUESTERS), binary index of grant_oh (0 when no grant).
REQ-012 SHALL have port grant_valid, output, 1, grant_oh is nonzero.

Function
REQ-013 SHALL select the grant in this priority order: locked owner; burst continuation; high-class round robin; low-class round robin.
REQ-014 SHALL grant the lock owner whenever locked=1, regardless of request, class or credits.
REQ-015 SHALL continue a burst by granting the holder when holder_valid=1, the holder is requesting, and (the holder is high class or no high-class request is active).
REQ-016 SHALL otherwise arbitrate among high-class requests if any exist, else among low-class requests, each class searching upward with wrap-around from its own one-hot pointer.
REQ-017 SHALL, on an accepted new (non-continuation) grant, update that class pointer to the grantee rotated left by one, set the holder to the grantee and load credits = max(weight,1) - 1.
REQ-018 SHALL, on an accepted continuation, decrement credits, saturating at 0.
REQ-019 SHALL clear holder_valid at the edge where credits become 0 after an accept, when the holder's request is low while it is not granted, or when a high-class grant is accepted while a low-class holder exists; a preempted burst is forfeited.
REQ-020 SHALL, on grant_accept=1 with lock=1, set locked=1 and lock owner = grantee; while locked, holder_valid SHALL NOT clear.
REQ-021 SHALL clear locked on grant_accept=1 with lock=0, and treat that beat as a normal accept for credits and release.
REQ-022 SHALL make no state change when grant_accept=1 and grant_valid=0, or when grant_accept=0 (except release on request drop, REQ-019).
REQ-023 SHALL treat weight=0 as weight=1, so that with all weights 1 it degenerates to a pure per-class round robin.
REQ-024 SHALL never assert more than one bit of grant_oh (assertion in simulation).

Reset
REQ-025 SHALL, on reset, set both class pointers to one-hot bit 0, holder_valid=0, credits=0, locked=0.
REQ-026 SHALL produce grant_oh=0, grant_idx=0, grant_valid=0 in reset with request=0.
REQ-027 SHALL, on reset asserted mid-burst or mid-lock, abandon the burst or lock immediately; the first grant after reset follows REQ-016.

Structure
REQ-028 SHALL place no typedefs in the shared package; all widths derive from the module parameters.
REQ-029 SHALL use a combinational sub-module rr_pick(request, priority_oh -> grant_oh), instantiated once per class.

Verification
REQ-030 SHALL cover: N=4, all weights 1, all low class, request=4'b1111, accept every cycle -> grants 0,1,2,3,0.
REQ-031 SHALL cover: weight[1]=3, request=4'b0011, accept every cycle -> grants 0,1,1,1,0,1,1,1.
REQ-032 SHALL cover: requester 2 low class in a weight-4 burst (2 beats done), requester 3 high class raises request -> grant 3 in the same cycle; after 3 drops, requester 2 starts a fresh 4-beat burst only when its low-class pointer turn comes up.
REQ-033 SHALL cover: accept of requester 1 with lock=1 for 3 beats while request[1] drops and request[0] is asserted -> grant stays 1; lock=0 accept -> next grant 0.
REQ-034 SHALL cover: reset asserted during a lock -> grant_valid=0 while request=0; after release with request=4'b1000 -> grant 3, pointer at bit 0.
REQ-035 SHALL cover: grant_accept=0 for 5 cycles with request=4'b0110 -> grant_oh stays 4'b0010 and pointers and credits are unchanged.
